// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: per-stage instr/PC/inc_PC registers, backward stall chain, bubble insertion and front-end flush.
// One edge per stage, stall/fetch_ready combinational; PIPE_CTRL_PERF_EN adds stall/retire counters.
module pipeline_ctrl #(
  parameter int          XLEN         = 32,
  parameter int          STAGES       = 4,
  parameter int          FLUSH_STAGES = 2,
  parameter logic [31:0] NOP          = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_valid,
  input  logic [31:0]              fetch_instr,
  input  logic [XLEN-1:0]          fetch_pc,
  input  logic [XLEN-1:0]          fetch_inc_pc,
  output logic                     fetch_ready,
  input  logic [STAGES-1:0]        stall_req,
  input  logic                     flush,
  output logic [STAGES-1:0]        stall,
  output logic [STAGES-1:0]        stage_valid,
  output logic [32*STAGES-1:0]     stage_instr,
  output logic [XLEN*STAGES-1:0]   stage_pc,
  output logic [XLEN*STAGES-1:0]   stage_inc_pc,
  output logic [31:0]              perf_stall_cnt,
  output logic [31:0]              perf_retire_cnt
);

  logic [31:0]       instr_q [STAGES];
  logic [XLEN-1:0]   pc_q    [STAGES];
  logic [XLEN-1:0]   inc_q   [STAGES];
  logic [STAGES-1:0] valid_q;

  // Each stall bit is an independent OR over the requests at and above it, so no comb loop.
  genvar g;
  generate
    for (g = 0; g < STAGES; g++) begin : g_stage
      assign stall[g]                      = |stall_req[STAGES-1:g];
      assign stage_instr[32*g +: 32]       = instr_q[g];
      assign stage_pc[XLEN*g +: XLEN]      = pc_q[g];
      assign stage_inc_pc[XLEN*g +: XLEN]  = inc_q[g];
    end
  endgenerate

  assign fetch_ready = ~stall[0] & ~flush;
  assign stage_valid = valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        instr_q[i] <= NOP;
        pc_q[i]    <= '0;
        inc_q[i]   <= '0;
      end
    end else begin
      if (flush || (!stall[0] && !fetch_valid)) begin
        valid_q[0] <= 1'b0;
        instr_q[0] <= NOP;
      end else if (!stall[0]) begin
        valid_q[0] <= 1'b1;
        instr_q[0] <= fetch_instr;
        pc_q[0]    <= fetch_pc;
        inc_q[0]   <= fetch_inc_pc;
      end

      for (int i = 1; i < STAGES; i++) begin
        if (flush && (i < FLUSH_STAGES)) begin
          valid_q[i] <= 1'b0;
          instr_q[i] <= NOP;
        end else if (!stall[i]) begin
          // Advancing behind a held or killed predecessor: insert a bubble, PCs left as-is.
          if (stall[i-1] || (flush && ((i - 1) < FLUSH_STAGES))) begin
            valid_q[i] <= 1'b0;
            instr_q[i] <= NOP;
          end else begin
            valid_q[i] <= valid_q[i-1];
            instr_q[i] <= instr_q[i-1];
            pc_q[i]    <= pc_q[i-1];
            inc_q[i]   <= inc_q[i-1];
          end
        end
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] retire_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      if (stall[0]) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (!stall[STAGES-1] && valid_q[STAGES-1]) begin
        retire_cnt_q <= retire_cnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_retire_cnt = retire_cnt_q;
`else
  assign perf_stall_cnt  = '0;
  assign perf_retire_cnt = '0;
`endif

endmodule
